bcd_display_scanner: RTL
========================

BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 Parameter CLK_DIV, default 1000, clk cycles each digit is lit (minimum 2).
REQ-002 Parameter BLINK_DIV, default 64, complete scan frames per overflow-blink phase toggle (minimum 1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-005 bcd_in  input  12  three BCD digits from ALU result; [3:0] units, [7:4] tens, [11:8] hundreds.
REQ-006 carry_in  input  1  ALU CarryOUT paired with bcd_in.
REQ-007 ovf_in  input  1  ALU overflow paired with bcd_in.
REQ-008 in_valid  input  1  producer offers bcd_in/carry_in/ovf_in this cycle.
REQ-009 in_ready  output  1  block can accept; transfer when in_valid and in_ready both high.
REQ-010 seg  output  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}.
REQ-011 dp  output  1  decimal point, active-high.
REQ-012 an  output  3  digit anodes, active-low, an[0] units.

Function
REQ-013 Accepted word SHALL be stored in a shadow register; in_ready SHALL be low while shadow is full.
REQ-014 Scan FSM SHALL cycle S_D0 -> S_D1 -> S_D2 -> S_D0, each state held exactly CLK_DIV cycles by a prescaler counter.
REQ-015 In S_Dn exactly one an bit (an[n]) SHALL be low; seg SHALL carry the decoded digit n of the display register.
REQ-016 Frame end is the last cycle of S_D2; at frame end a full shadow SHALL move into the display register and shadow SHALL become empty (in_ready high next cycle).
REQ-017 in_valid while shadow full SHALL be ignored; no overwrite, no data loss of the held word.
REQ-018 A word accepted on the frame-end cycle with shadow empty SHALL wait for the following frame end.
REQ-019 Digit decode: 0-9 standard seven-segment (0=7'h3F, 1=7'h06, 2=7'h5B, 5=7'h6D, 9=7'h6F); nibbles A-F SHALL show dash 7'h40.
REQ-020 dp SHALL be high only in S_D0 when displayed carry is 1.
REQ-021 Blink counter SHALL count frame ends modulo BLINK_DIV and toggle blink phase at wrap; when displayed ovf is 1 and phase is 1, an SHALL be 3'b111 (seg/dp don't-care); ovf 0 SHALL never blank.
REQ-022 Outputs an, seg, dp SHALL be registered; latency from state change to output one cycle.

Reset
REQ-023 On rst_n low: an=3'b111, seg=7'h00, dp=0, in_ready=1, shadow empty, display register/carry/ovf=0, FSM S_D0, prescaler and blink counters 0, phase 0.
REQ-024 Reset mid-frame or mid-handshake SHALL discard shadow and display contents immediately; first lit digit after release is an[0] showing 0.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN: when defined, hundreds digit SHALL be blanked (an[2] high) if 0, and tens if 0 and hundreds 0; units never blanked.
REQ-026 Without LEADING_ZERO_BLANK_EN all three digits SHALL always be lit (subject only to REQ-021).

Structure
REQ-027 Package bcd_disp_pkg SHALL hold the FSM state enum, seven-segment constants (digits 0-9, dash, blank) and digit-count constant.
REQ-028 Sub-module bcd_to_seg7 SHALL be the combinational nibble-to-segment decoder, instantiated once on the muxed digit.

Verification (CLK_DIV=4, BLINK_DIV=2)
REQ-029 Reset release, no input -> an walks 110,101,011 every 4 cycles, seg=7'h3F each digit, dp=0, in_ready=1.
REQ-030 Accept bcd_in=12'h125, carry 1 -> next frame: an[0] seg 7'h6D dp=1, an[1] 7'h5B, an[2] 7'h06.
REQ-031 Two back-to-back in_valid words 12'h111 then 12'h999 -> second held off (in_ready 0) until frame end, then displayed one frame after 12'h111.
REQ-032 bcd_in=12'h0A3 -> tens digit shows 7'h40.
REQ-033 ovf_in=1 -> an all 1 for 2 frames, active for 2 frames, repeating; ovf_in=0 reload stops blanking.
REQ-034 With LEADING_ZERO_BLANK_EN, bcd_in=12'h007 -> an[2], an[1] never low; units shows 7'h07.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_disp_pkg
// Description : Shared types and seven-segment constants for the BCD scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_disp_pkg;

   localparam int NUM_DIGITS = 3;

   typedef enum logic [1:0] {
      S_D0 = 2'd0,
      S_D1 = 2'd1,
      S_D2 = 2'd2
   } scan_state_e;

   // Segment order {g,f,e,d,c,b,a}, active-high
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef struct packed {
      logic [11:0] bcd;
      logic        carry;
      logic        ovf;
   } disp_word_t;

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_seg7
// Description : Combinational BCD nibble to seven-segment decoder; A-F show a dash.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
   import bcd_disp_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      case (digit_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_scanner
// Description : Three-digit multiplexed BCD display scanner with shadow-register
//               handshake, carry decimal point and overflow blink.
//               Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_scanner
   import bcd_disp_pkg::*;
#(
   parameter int CLK_DIV   = 1000,
   parameter int BLINK_DIV = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [11:0]           bcd_in,
   input  logic                  carry_in,
   input  logic                  ovf_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [NUM_DIGITS-1:0] an
);

   localparam int PRESC_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   scan_state_e            state_q, state_d;
   logic [PRESC_W-1:0]     presc_q, presc_d;
   disp_word_t             shadow_q, shadow_d;
   disp_word_t             disp_q, disp_d;
   logic                   shadow_full_q, shadow_full_d;
   logic [BLINK_W-1:0]     blink_cnt_q, blink_cnt_d;
   logic                   blink_phase_q, blink_phase_d;
   logic [NUM_DIGITS-1:0]  an_q, an_d;
   logic [6:0]             seg_q, seg_d;
   logic                   dp_q, dp_d;

   logic                   presc_wrap;
   logic                   frame_end;
   logic                   accept;
   logic [3:0]             digit_mux;
   logic [6:0]             digit_seg;
   logic                   digit_blank;

   assign presc_wrap = (presc_q == PRESC_LAST);
   assign frame_end  = presc_wrap && (state_q == S_D2);
   assign in_ready   = !shadow_full_q;
   assign accept     = in_valid && !shadow_full_q;

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_D0;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (presc_wrap) begin
         case (state_q)
            S_D0:    state_d = S_D1;
            S_D1:    state_d = S_D2;
            default: state_d = S_D0;
         endcase
      end
   end

   // ------------------------------------------------------------- datapath
   always_comb begin
      presc_d       = presc_wrap ? '0 : presc_q + PRESC_W'(1);
      shadow_d      = shadow_q;
      shadow_full_d = shadow_full_q;
      disp_d        = disp_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;

      // Accept is impossible while full, so the transfer and a new accept never collide
      if (frame_end && shadow_full_q) begin
         disp_d        = shadow_q;
         shadow_full_d = 1'b0;
      end
      if (accept) begin
         shadow_d.bcd   = bcd_in;
         shadow_d.carry = carry_in;
         shadow_d.ovf   = ovf_in;
         shadow_full_d  = 1'b1;
      end

      if (frame_end) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = !blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q       <= '0;
         shadow_q      <= '0;
         shadow_full_q <= 1'b0;
         disp_q        <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else begin
         presc_q       <= presc_d;
         shadow_q      <= shadow_d;
         shadow_full_q <= shadow_full_d;
         disp_q        <= disp_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   // ----------------------------------------------------------- digit mux
   always_comb begin
      case (state_q)
         S_D0:    digit_mux = disp_q.bcd[3:0];
         S_D1:    digit_mux = disp_q.bcd[7:4];
         default: digit_mux = disp_q.bcd[11:8];
      endcase
   end

   bcd_to_seg7 u_seg7 (
      .digit_i (digit_mux),
      .seg_o   (digit_seg)
   );

`ifdef LEADING_ZERO_BLANK_EN
   always_comb begin
      digit_blank = ((state_q == S_D2) && (disp_q.bcd[11:8] == 4'd0)) ||
                    ((state_q == S_D1) && (disp_q.bcd[11:4] == 8'd0));
   end
`else
   assign digit_blank = 1'b0;
`endif

   // -------------------------------------------------------- output logic
   always_comb begin
      an_d  = 3'b111;
      seg_d = digit_seg;
      dp_d  = 1'b0;
      case (state_q)
         S_D0: begin
            an_d = 3'b110;
            dp_d = disp_q.carry;
         end
         S_D1:    an_d = 3'b101;
         S_D2:    an_d = 3'b011;
         default: an_d = 3'b111;
      endcase
      if (digit_blank || (disp_q.ovf && blink_phase_q)) begin
         an_d  = 3'b111;
         seg_d = SEG_BLANK;
         dp_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_q  <= 3'b111;
         seg_q <= SEG_BLANK;
         dp_q  <= 1'b0;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule
`default_nettype wire
